// File: rtl/data_mem_resp.sv
// data_mem_resp: word-addressed data memory with power-up clear FSM, flow-through reads and access stats
// Ports: clk; rst_n async active-low reset; CEN chip enable (low = access); WEN (low = write);
//   A word address; D write data; OEN output enable (low = drive Q); Q read data (0 when not driven);
//   ready high once the clear fill is done; err sticky bad-access flag;
//   rd_cnt/wr_cnt saturating counts of accepted reads/writes.
// Build option: define DATA_MEM_RESP_STATS_EN to build the counters; otherwise they read as 0.
module data_mem_resp #(
  parameter int WORDS = 128,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CEN,
  input  logic        WEN,
  input  logic [6:0]  A,
  input  logic [31:0] D,
  input  logic        OEN,
  output logic [31:0] Q,
  output logic        ready,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [0:0] INIT = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  logic [0:0] state;
  logic [6:0] ptr;
  logic [31:0] mem [WORDS];
  logic in_range, req, acc;
  // rst_n gates ready directly so a no-clear build still reads not-ready while held in reset
  assign ready = rst_n && state == READY;
  assign in_range = {25'd0, A} < 32'(WORDS);
  assign req = !CEN;
  assign acc = req && ready && in_range;
  assign Q = (acc && WEN && !OEN) ? mem[A] : 32'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      ptr <= '0;
      err <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        ptr <= ptr + 7'd1;
        if (ptr == 7'(WORDS - 1)) state <= READY;
      end
      if (req && !acc) err <= 1'b1;
    end
  // No reset on the array: reset must leave contents intact, and the fill is suppressed while rst_n is low
  always_ff @(posedge clk)
    if (rst_n && state == CLEAR) mem[ptr] <= '0;
    else if (acc && !WEN) mem[A] <= D;
`ifdef DATA_MEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (acc && WEN && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (acc && !WEN && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
`else
  assign rd_cnt = 16'h0;
  assign wr_cnt = 16'h0;
`endif
endmodule
